// File: rtl/bit_sample_counter.sv
// Oversampled bit/frame timing counter.
// Counts enabled oversample ticks within a bit period and bit periods within a
// frame, and emits registered strobes at mid-bit, end of bit and end of frame.
module bit_sample_counter #(
  parameter int SAMPLE_W        = 4,
  parameter int SAMPLES_PER_BIT = 16,
  parameter int MID_SAMPLE      = 8,
  parameter int BIT_W           = 4,
  parameter int BITS_PER_FRAME  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                start,
  input  logic                abort,
  output logic [SAMPLE_W-1:0] sample_cnt,
  output logic [BIT_W-1:0]    bit_cnt,
  output logic                busy,
  output logic                mid_strobe,
  output logic                bit_done,
  output logic                frame_done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SAMPLE_W-1:0] SAMP_LAST = SAMPLE_W'(SAMPLES_PER_BIT - 1);
  localparam logic [SAMPLE_W-1:0] SAMP_MID  = SAMPLE_W'(MID_SAMPLE);
  localparam logic [SAMPLE_W-1:0] SAMP_ONE  = SAMPLE_W'(1);
  localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(BITS_PER_FRAME - 1);
  localparam logic [BIT_W-1:0]    BIT_ONE   = BIT_W'(1);
  // Mid strobe also fires when the sample count lands on 0 (RUN entry or bit wrap).
  localparam logic                MID_AT_ZERO = (MID_SAMPLE == 0);

  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] sample_d;
  logic [BIT_W-1:0]    bit_d;
  logic                mid_d, bit_done_d, frame_done_d;

  assign busy = (state_q == RUN);

  // Next-state, next-count and next-strobe decode.
  always_comb begin
    state_d      = state_q;
    sample_d     = sample_cnt;
    bit_d        = bit_cnt;
    mid_d        = 1'b0;
    bit_done_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        sample_d = '0;
        bit_d    = '0;
        if (start && !abort) begin
          state_d = RUN;
          mid_d   = MID_AT_ZERO;
        end
      end
      RUN: begin
        if (abort) begin
          // Abort outranks enable and start; no completion strobes.
          state_d  = IDLE;
          sample_d = '0;
          bit_d    = '0;
        end else if (enable) begin
          if (sample_cnt == SAMP_LAST) begin
            sample_d   = '0;
            bit_done_d = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state_d      = IDLE;
              bit_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              bit_d = bit_cnt + BIT_ONE;
              mid_d = MID_AT_ZERO;
            end
          end else begin
            sample_d = sample_cnt + SAMP_ONE;
            mid_d    = ((sample_cnt + SAMP_ONE) == SAMP_MID);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        sample_d = '0;
        bit_d    = '0;
      end
    endcase
  end

  // State, counter and strobe registers; reset forces everything idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      mid_strobe <= 1'b0;
      bit_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      sample_cnt <= sample_d;
      bit_cnt    <= bit_d;
      mid_strobe <= mid_d;
      bit_done   <= bit_done_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_bit_sample_counter.sv
// Testbench for bit_sample_counter: default-parameter instance plus a small
// SAMPLES_PER_BIT=4 / MID_SAMPLE=0 / BITS_PER_FRAME=1 instance.
module tb_bit_sample_counter;

  logic       clk = 1'b0;
  logic       rst, enable, start, abort;
  logic [3:0] sample_cnt, bit_cnt;
  logic       busy, mid_strobe, bit_done, frame_done;
  logic [1:0] sample_cnt2;
  logic [0:0] bit_cnt2;
  logic       busy2, mid_strobe2, bit_done2, frame_done2;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;

  always #5 clk = ~clk;

  bit_sample_counter dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .abort(abort),
    .sample_cnt(sample_cnt), .bit_cnt(bit_cnt), .busy(busy),
    .mid_strobe(mid_strobe), .bit_done(bit_done), .frame_done(frame_done)
  );

  bit_sample_counter #(
    .SAMPLE_W(2), .SAMPLES_PER_BIT(4), .MID_SAMPLE(0), .BIT_W(1), .BITS_PER_FRAME(1)
  ) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .abort(abort),
    .sample_cnt(sample_cnt2), .bit_cnt(bit_cnt2), .busy(busy2),
    .mid_strobe(mid_strobe2), .bit_done(bit_done2), .frame_done(frame_done2)
  );

  typedef struct {
    logic r, st, ab, en;
    int   s, b, bsy, mid, bd, fd;
  } vec_t;

  vec_t vecs[13];

  task automatic step(input logic r, input logic st, input logic ab, input logic en);
    rst = r; start = st; abort = ab; enable = en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_dut(input string nm, input int s, input int b, input int bsy,
                         input int mid, input int bd, input int fd);
    chk({nm, "_sample_cnt"}, int'(sample_cnt), s);
    chk({nm, "_bit_cnt"},    int'(bit_cnt),    b);
    chk({nm, "_busy"},       int'(busy),       bsy);
    chk({nm, "_mid_strobe"}, int'(mid_strobe), mid);
    chk({nm, "_bit_done"},   int'(bit_done),   bd);
    chk({nm, "_frame_done"}, int'(frame_done), fd);
  endtask

  // Expected outputs after 'ticks' enabled ticks of a default frame.
  task automatic expect_run(input string nm, input logic en);
    int n;
    n = ticks;
    if (en)
      chk_dut(nm, n % 16, (n / 16) % 10, int'(n < 160), int'(n % 16 == 8),
              int'(n % 16 == 0), int'(n == 160));
    else
      chk_dut(nm, n % 16, (n / 16) % 10, int'(n < 160), 0, 0, 0);
  endtask

  task automatic begin_frame(input string nm);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks = 0;
    chk_dut(nm, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic run_ticks(input string nm, input int count);
    for (int k = 0; k < count; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      ticks++;
      expect_run(nm, 1'b1);
    end
  endtask

  initial begin
    int mids, bds, fd_cycle;
    logic en;
    rst = 1'b1; start = 1'b0; abort = 1'b0; enable = 1'b0;

    //           r  st ab en   s  b  bsy mid bd fd
    vecs[0]  = '{1, 0, 0, 0,   0, 0, 0,  0,  0, 0};  // reset
    vecs[1]  = '{0, 1, 1, 1,   0, 0, 0,  0,  0, 0};  // start+abort in IDLE
    vecs[2]  = '{0, 0, 0, 1,   0, 0, 0,  0,  0, 0};  // enable alone in IDLE
    vecs[3]  = '{0, 1, 0, 0,   0, 0, 1,  0,  0, 0};  // start without enable
    vecs[4]  = '{0, 0, 0, 0,   0, 0, 1,  0,  0, 0};  // hold
    vecs[5]  = '{0, 0, 0, 1,   1, 0, 1,  0,  0, 0};  // tick
    vecs[6]  = '{0, 1, 0, 1,   2, 0, 1,  0,  0, 0};  // start ignored in RUN
    vecs[7]  = '{0, 0, 0, 0,   2, 0, 1,  0,  0, 0};  // hold
    vecs[8]  = '{0, 1, 1, 1,   0, 0, 0,  0,  0, 0};  // abort beats start/enable
    vecs[9]  = '{0, 1, 0, 1,   0, 0, 1,  0,  0, 0};  // start with enable
    vecs[10] = '{1, 1, 0, 1,   0, 0, 0,  0,  0, 0};  // reset overrides
    vecs[11] = '{0, 1, 0, 0,   0, 0, 1,  0,  0, 0};  // start right after reset
    vecs[12] = '{0, 0, 0, 1,   1, 0, 1,  0,  0, 0};  // tick

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].r, vecs[i].st, vecs[i].ab, vecs[i].en);
      chk_dut($sformatf("vec%0d", i), vecs[i].s, vecs[i].b, vecs[i].bsy,
              vecs[i].mid, vecs[i].bd, vecs[i].fd);
    end

    // Full frame with enable held high.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    begin_frame("full_start");
    run_ticks("full", 160);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_dut("full_after", 0, 0, 0, 0, 0, 0);

    // Enable toggling: idle cycle then tick, 320 cycles total.
    begin_frame("alt_start");
    mids = 0; bds = 0; fd_cycle = -1;
    for (int c = 1; c <= 320; c++) begin
      en = (c % 2 == 0);
      step(1'b0, 1'b0, 1'b0, en);
      if (en) ticks++;
      expect_run("alt", en);
      if (mid_strobe) mids++;
      if (bit_done) bds++;
      if (frame_done) fd_cycle = c;
    end
    chk("alt_mid_count", mids, 10);
    chk("alt_bit_done_count", bds, 10);
    chk("alt_frame_done_cycle", fd_cycle, 320);

    // Abort at bit 3, sample 7, then a fresh full frame.
    begin_frame("abort_start");
    run_ticks("abort_pre", 55);
    chk_dut("abort_at", 7, 3, 1, 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk_dut("abort_next", 0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_dut("abort_idle", 0, 0, 0, 0, 0, 0);
    begin_frame("abort_restart");
    run_ticks("abort_frame", 160);

    // Start re-asserted at bit 4 is ignored.
    begin_frame("restart_start");
    run_ticks("restart_pre", 64);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    ticks++;
    expect_run("restart_tick", 1'b1);
    run_ticks("restart_rest", 95);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_dut("idle_start_abort", 0, 0, 0, 0, 0, 0);

    // Reset for two cycles mid-frame at bit 5.
    begin_frame("rst_start");
    run_ticks("rst_pre", 83);
    chk_dut("rst_at", 3, 5, 1, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk_dut("rst_c1", 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk_dut("rst_c2", 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_dut("rst_after", 0, 0, 0, 0, 0, 0);
    end

    // Small instance: mid strobe on RUN entry, single 4-tick bit per frame.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("p2_entry_mid", int'(mid_strobe2), 1);
    chk("p2_entry_busy", int'(busy2), 1);
    chk("p2_entry_sample", int'(sample_cnt2), 0);
    chk("p2_entry_bit_done", int'(bit_done2), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("p2_hold_mid", int'(mid_strobe2), 0);
    chk("p2_hold_busy", int'(busy2), 1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("p2_tick_sample", int'(sample_cnt2), k);
      chk("p2_tick_mid", int'(mid_strobe2), 0);
      chk("p2_tick_bit_done", int'(bit_done2), 0);
      chk("p2_tick_frame_done", int'(frame_done2), 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("p2_end_bit_done", int'(bit_done2), 1);
    chk("p2_end_frame_done", int'(frame_done2), 1);
    chk("p2_end_busy", int'(busy2), 0);
    chk("p2_end_sample", int'(sample_cnt2), 0);
    chk("p2_end_bit_cnt", int'(bit_cnt2), 0);
    chk("p2_end_mid", int'(mid_strobe2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
